// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-entry skid buffer stage; in_* upstream handshake, out_* registered head, flush squash, sticky halted, saturating stall_cnt
module pipe_stage_skid #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_halt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_halt,
  input  logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
  state_e state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d, skid_q, skid_d;
  logic head_halt_q, head_halt_d, skid_halt_q, skid_halt_d;
  logic ready_q, ready_d, halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic accept, deliver, load_head, load_skid, skid_to_head;
  assign accept = in_valid & ready_q;
  assign deliver = out_valid & out_ready;
  assign out_valid = state_q != EMPTY;
  assign in_ready = ready_q;
  assign out_data = head_q;
  assign out_halt = head_halt_q;
  assign halted = halted_q;
  assign stall_cnt = cnt_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: state_d = accept ? ONE : EMPTY;
      ONE: state_d = (accept & ~deliver) ? TWO : (deliver & ~accept) ? EMPTY : ONE;
      TWO: state_d = deliver ? ONE : TWO;
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end
  assign load_head = ~flush & accept & ((state_q == EMPTY) | ((state_q == ONE) & deliver));
  assign load_skid = ~flush & accept & (state_q == ONE) & ~deliver;
  assign skid_to_head = ~flush & deliver & (state_q == TWO);
  assign head_d = skid_to_head ? skid_q : load_head ? in_data : head_q;
  assign head_halt_d = skid_to_head ? skid_halt_q : load_head ? in_halt : head_halt_q;
  assign skid_d = load_skid ? in_data : skid_q;
  assign skid_halt_d = load_skid ? in_halt : skid_halt_q;
  assign halted_d = halted_q | (deliver & head_halt_q);
  assign ready_d = (state_d != TWO) & ~halted_d;
  assign cnt_d = (out_valid & ~out_ready & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= EMPTY;
      head_q <= '0;
      head_halt_q <= 1'b0;
      skid_q <= '0;
      skid_halt_q <= 1'b0;
      ready_q <= 1'b0;
      halted_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      head_halt_q <= head_halt_d;
      skid_q <= skid_d;
      skid_halt_q <= skid_halt_d;
      ready_q <= ready_d;
      halted_q <= halted_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed table, hand sequences and random stimulus against a queue reference model
module tb_pipe_stage_skid;
  localparam int W = 32;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic in_valid = 1'b0, in_halt = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, out_halt, halted;
  logic in_ready2, out_valid2, out_halt2, halted2;
  logic [W-1:0] out_data, out_data2;
  logic [15:0] stall_cnt;
  logic [1:0] stall_cnt2;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic h;
    logic [W-1:0] d;
  } ent_t;
  ent_t q[$];
  logic m_rdy = 1'b0;
  logic m_halted = 1'b0;
  int m_stall = 0;
  typedef struct {
    logic iv;
    logic [W-1:0] d;
    logic h;
    logic ordy;
    logic fl;
    logic ov;
    logic [W-1:0] od;
    logic ir;
    logic hlt;
    int sc;
  } vec_t;
  vec_t tbl[18];

  always #5 CLK = ~CLK;

  pipe_stage_skid #(.WIDTH(W), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_halt(in_halt), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_halt(out_halt), .flush(flush), .halted(halted), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.WIDTH(W), .CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_halt(in_halt), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_halt(out_halt2), .flush(flush), .halted(halted2), .stall_cnt(stall_cnt2)
  );

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      q.delete();
      m_rdy = 1'b0;
      m_halted = 1'b0;
      m_stall = 0;
    end else begin : mdl
      bit acc, del;
      acc = in_valid && m_rdy;
      del = q.size() > 0 && out_ready;
      if (q.size() > 0 && !out_ready) m_stall++;
      if (del) begin
        if (q[0].h) m_halted = 1'b1;
        void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (acc) q.push_back('{h: in_halt, d: in_data});
      m_rdy = q.size() < 2 && !m_halted;
    end
  end

  function automatic vec_t mk(logic iv, logic [W-1:0] d, logic h, logic ordy, logic fl,
                              logic ov, logic [W-1:0] od, logic ir, logic hlt, int sc);
    mk = '{iv: iv, d: d, h: h, ordy: ordy, fl: fl, ov: ov, od: od, ir: ir, hlt: hlt, sc: sc};
  endfunction

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic check_model();
    chk("model_out_valid", out_valid, q.size() > 0);
    chk("model_out_valid2", out_valid2, q.size() > 0);
    if (q.size() > 0) begin
      chk("model_out_data", out_data, q[0].d);
      chk("model_out_halt", out_halt, q[0].h);
      chk("model_out_data2", out_data2, q[0].d);
    end
    chk("model_in_ready", in_ready, m_rdy);
    chk("model_halted", halted, m_halted);
    chk("model_stall_cnt", stall_cnt, m_stall > 65535 ? 65535 : m_stall);
    chk("model_stall_cnt_w2", stall_cnt2, m_stall > 3 ? 3 : m_stall);
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
    check_model();
  endtask

  task automatic drive(logic iv, logic [W-1:0] d, logic h, logic ordy, logic fl);
    in_valid = iv;
    in_data = d;
    in_halt = h;
    out_ready = ordy;
    flush = fl;
  endtask

  task automatic do_reset();
    #2 RST = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_halt", out_halt, 0);
    chk("rst_halted", halted, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_stall_cnt_w2", stall_cnt2, 0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1 chk("rst_release_in_ready", in_ready, 0);
    @(negedge CLK);
    check_model();
    chk("first_edge_in_ready", in_ready, 1);
  endtask

  initial begin
    tbl[0]  = mk(1, 'h1,  0, 1, 0, 1, 'h1,  1, 0, 0);
    tbl[1]  = mk(1, 'h2,  0, 1, 0, 1, 'h2,  1, 0, 0);
    tbl[2]  = mk(1, 'h3,  0, 0, 0, 1, 'h2,  0, 0, 1);
    tbl[3]  = mk(1, 'h4,  0, 0, 0, 1, 'h2,  0, 0, 2);
    tbl[4]  = mk(1, 'h4,  0, 0, 0, 1, 'h2,  0, 0, 3);
    tbl[5]  = mk(1, 'h4,  0, 1, 0, 1, 'h3,  1, 0, 3);
    tbl[6]  = mk(1, 'h4,  0, 1, 0, 1, 'h4,  1, 0, 3);
    tbl[7]  = mk(1, 'h5,  0, 0, 0, 1, 'h4,  0, 0, 4);
    tbl[8]  = mk(1, 'h6,  0, 0, 1, 0, 'h0,  1, 0, 5);
    tbl[9]  = mk(0, 'h0,  0, 1, 0, 0, 'h0,  1, 0, 5);
    tbl[10] = mk(1, 'h7,  0, 1, 1, 0, 'h0,  1, 0, 5);
    tbl[11] = mk(1, 'h8,  0, 1, 0, 1, 'h8,  1, 0, 5);
    tbl[12] = mk(0, 'h0,  0, 1, 0, 0, 'h0,  1, 0, 5);
    tbl[13] = mk(1, 'hAA, 1, 0, 0, 1, 'hAA, 1, 0, 5);
    tbl[14] = mk(1, 'hBB, 0, 0, 0, 1, 'hAA, 0, 0, 6);
    tbl[15] = mk(0, 'h0,  0, 1, 0, 1, 'hBB, 0, 1, 6);
    tbl[16] = mk(1, 'hCC, 0, 1, 0, 0, 'h0,  0, 1, 6);
    tbl[17] = mk(1, 'hDD, 0, 1, 0, 0, 'h0,  0, 1, 6);
    @(negedge CLK);
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, W'(i), 1'b0, 1'b1, 1'b0);
      step();
      chk($sformatf("stream%0d_out_data", i), out_data, i);
      chk($sformatf("stream%0d_out_valid", i), out_valid, 1);
    end
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step();
    chk("stream_stall_cnt", stall_cnt, 0);
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].h, tbl[i].ordy, tbl[i].fl);
      step();
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].ov);
      if (tbl[i].ov) chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].od);
      chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].ir);
      chk($sformatf("vec%0d_halted", i), halted, tbl[i].hlt);
      chk($sformatf("vec%0d_stall_cnt", i), stall_cnt, tbl[i].sc);
      chk($sformatf("vec%0d_stall_cnt_w2", i), stall_cnt2, tbl[i].sc > 3 ? 3 : tbl[i].sc);
    end
    do_reset();
    drive(1'b1, 'h11, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 'h22, 1'b0, 1'b0, 1'b0);
    step();
    chk("two_out_valid", out_valid, 1);
    chk("two_in_ready", in_ready, 0);
    chk("two_out_data", out_data, 'h11);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 99) == 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      step();
      if (i % 500 == 499) do_reset();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Parameters
REQ-001 SHALL: WIDTH, default 128, payload bits per entry (range 1..1024).
REQ-002 SHALL: CNT_W, default 16, width of the stall counter.

Interface
REQ-003 SHALL: CLK  input  1  rising-edge clock.
REQ-004 SHALL: RST  input  1  asynchronous reset, active-high.
REQ-005 SHALL: in_valid  input  1  upstream stage presents an entry.
REQ-006 SHALL: in_ready  output  1  stage can accept an entry this cycle; registered.
REQ-007 SHALL: in_data  input  WIDTH  upstream payload (opcode, control, operands).
REQ-008 SHALL: in_halt  input  1  entry is a halt instruction.
REQ-009 SHALL: out_valid  output  1  head entry valid.
REQ-010 SHALL: out_ready  input  1  downstream accepts the head entry.
REQ-011 SHALL: out_data  output  WIDTH  head payload; registered, no combinational path from in_data.
REQ-012 SHALL: out_halt  output  1  halt flag of the head entry.
REQ-013 SHALL: flush  input  1  squash all held entries (branch or jump resolution).
REQ-014 SHALL: halted  output  1  sticky flag: a halt entry has left the stage.
REQ-015 SHALL: stall_cnt  output  CNT_W  saturating count of output stall cycles.

Function
REQ-016 SHALL: two-entry skid buffer (head and skid registers) with states EMPTY, ONE, TWO.
REQ-017 SHALL: accept = in_valid & in_ready; deliver = out_valid & out_ready.
REQ-018 SHALL: EMPTY->ONE on accept; ONE->TWO on accept & !deliver; ONE->EMPTY on deliver & !accept; ONE holds on both or neither; TWO->ONE on deliver; TWO ignores in_valid.
REQ-019 SHALL: in_ready = (next state != TWO) & !halted, registered; a full stage never drops an entry.
REQ-020 SHALL: on deliver in TWO, skid moves to head in the same edge; order is strictly FIFO.
REQ-021 SHALL: out_valid = (state != EMPTY); out_data and out_halt come only from the head register.
REQ-022 SHALL: latency in->out is 1 cycle when EMPTY; sustained throughput is 1 entry/cycle with out_ready held high.
REQ-023 SHALL: flush forces state EMPTY at the next edge, discarding head, skid and any same-cycle accept; flush outranks accept and deliver.
REQ-024 SHALL: a deliver coincident with flush still counts as delivered downstream; halted updates from it.
REQ-025 SHALL: halted sets on deliver & out_halt and then holds until RST; while set, in_ready = 0.
REQ-026 SHALL: stall_cnt increments on each cycle with out_valid & !out_ready and saturates at 2^CNT_W-1; it is not cleared by flush.
REQ-027 SHALL: payload registers load only on accept or skid-to-head move; no enable-less updates.

Reset
REQ-028 SHALL: asynchronous RST forces state EMPTY, out_valid=0, in_ready=0, out_data=0, out_halt=0, halted=0, stall_cnt=0.
REQ-029 SHALL: in_ready rises to 1 on the first edge after RST deasserts.
REQ-030 SHALL: RST asserted mid-transfer discards all entries; no partial deliver is reported.

Verification
REQ-031 SHALL: back-to-back stream, in_valid=1, out_ready=1, data 0x1..0x8 -> out_data 0x1..0x8 on consecutive cycles, 1-cycle lag, stall_cnt=0.
REQ-032 SHALL: out_ready=0 for 3 cycles while in_valid=1 -> 2 entries held, in_ready=0 from cycle 2, stall_cnt=3; on release, entries arrive in order with none lost.
REQ-033 SHALL: flush in state TWO with in_valid=1 -> next cycle out_valid=0 and state EMPTY; the flushed-cycle input is never output.
REQ-034 SHALL: halt entry 0xAA with in_halt=1 delivered -> halted=1 next cycle, in_ready=0 thereafter; later in_valid is ignored.
REQ-035 SHALL: RST pulse mid-stream in state TWO -> all outputs return to reset values asynchronously.
REQ-036 SHALL: with CNT_W=2, 6 stall cycles -> stall_cnt saturates at 3.
